// File: rtl/fibo_pkg.sv
// Shared constants and state encoding for the Fibonacci counter slice.
package fibo_pkg;

  localparam int R_SIZE = 16;
  localparam int C_SIZE = 8;
  localparam int BCD_W  = 4;

  // One-hot converter states; also visible on the bus state field.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_DONE  = 3'b100
  } state_e;

endpackage

// File: rtl/fibo_bcd_converter_if.sv
// Bus between the Fibonacci counter side and the BCD converter.
// Optional macro: FIBO_AUTO_CAPTURE_EN adds the counter's Ready line.
//
// Handshake: the converter accepts start on a rising clock edge only while
// ready=1 (IDLE); start while ready=0 is dropped, never queued. done is a
// one-cycle pulse, and bcd is valid from that cycle until the next done.
interface fibo_bcd_converter_if #(
  parameter int R_SIZE = fibo_pkg::R_SIZE,
  parameter int DIGITS = 5
);

  logic                             start;
  logic [R_SIZE-1:0]                bin;
  logic                             ready;
  logic                             done;
  logic [fibo_pkg::BCD_W*DIGITS-1:0] bcd;
  logic [2:0]                       state;  // FSM state for monitoring
`ifdef FIBO_AUTO_CAPTURE_EN
  logic                             fibo_ready;

  modport master (output start, bin, fibo_ready, input ready, done, bcd, state);
  modport slave  (input start, bin, fibo_ready, output ready, done, bcd, state);
`else
  modport master (output start, bin, input ready, done, bcd, state);
  modport slave  (input start, bin, output ready, done, bcd, state);
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Result is at most 12, so the 4-bit add never wraps for legal digits.
  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/fibo_bcd_converter.sv
// Binary-to-packed-BCD converter, one shift-add-3 step per clock.
// Optional macro: FIBO_AUTO_CAPTURE_EN starts a conversion on a rising edge
// of the counter's Ready line as well as on start.
module fibo_bcd_converter
  import fibo_pkg::*;
#(
  parameter int R_SIZE = fibo_pkg::R_SIZE,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  fibo_bcd_converter_if.slave   bus
);

  localparam int W  = BCD_W * DIGITS;
  localparam int CW = $clog2(R_SIZE + 1);

  state_e            state_q, state_d;
  logic [R_SIZE-1:0] bin_sr_q, bin_sr_d;
  logic [W-1:0]      work_q, work_d;
  logic [W-1:0]      bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      work_adj;
  logic [W+R_SIZE-1:0] shift_v;
  logic              start_eff;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[g*BCD_W +: BCD_W]),
      .digit_o (work_adj[g*BCD_W +: BCD_W])
    );
  end

  // Corrected digits and remaining binary bits shift left as one word; the
  // carry out of the top digit is dropped (truncation when DIGITS is small).
  assign shift_v = {work_adj[W-2:0], bin_sr_q, 1'b0};

`ifdef FIBO_AUTO_CAPTURE_EN
  logic fibo_ready_q;

  // Ready history for edge detection; reset high so a level held out of
  // reset is not mistaken for a new result.
  always_ff @(posedge clock) begin
    if (reset) fibo_ready_q <= 1'b1;
    else       fibo_ready_q <= bus.fibo_ready;
  end

  assign start_eff = bus.start | (bus.fibo_ready & ~fibo_ready_q);
`else
  assign start_eff = bus.start;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bin_sr_q <= '0;
      work_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      work_q   <= work_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and datapath update for IDLE -> SHIFT x R_SIZE -> DONE.
  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    work_d   = work_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_eff) begin
          bin_sr_d = bus.bin;
          work_d   = '0;
          cnt_d    = CW'(R_SIZE);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d   = shift_v[W+R_SIZE-1:R_SIZE];
        bin_sr_d = shift_v[R_SIZE-1:0];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shift_v[W+R_SIZE-1:R_SIZE];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.bcd   = bcd_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_fibo_bcd_converter.sv
// Directed plus randomized bench for fibo_bcd_converter against a decimal
// reference model.
module tb_fibo_bcd_converter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [19:0] exp_q[$];

  always #5 clock = ~clock;

  fibo_bcd_converter_if #(.R_SIZE(16), .DIGITS(5)) bus ();

  fibo_bcd_converter #(.R_SIZE(16), .DIGITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: decimal digits by repeated division, low digit first.
  function automatic logic [19:0] bcd_ref(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (at negedges) for done, bounded; cyc counts negedges waited.
  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (bus.done === 1'b1) got = 1'b1;
    end
  endtask

  // One conversion from IDLE; optional ignored start pulse at cycle glitch_at.
  task automatic conv(input logic [15:0] b, input int glitch_at);
    logic [19:0] prev;
    int cyc;
    bit got, held_ok;
    prev    = bus.bcd;
    held_ok = 1'b1;
    got     = 1'b0;
    cyc     = 0;
    chk("ready_before", 32'(bus.ready), 32'd1);
    bus.bin   = b;
    bus.start = 1'b1;
    exp_q.push_back(bcd_ref(32'(b)));
    @(negedge clock);
    bus.start = 1'b0;
    bus.bin   = 16'($urandom);
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      bus.start = (cyc == glitch_at);
      if (cyc == glitch_at) bus.bin = 16'd9999;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.bcd !== prev) held_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'd16);
    chk("bcd", 32'(bus.bcd), 32'(exp_q.pop_front()));
    chk("bcd_held", 32'(held_ok), 32'd1);
    @(negedge clock);
    chk("done_1cyc", 32'(bus.done), 32'd0);
    chk("ready_after", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pulses;
    bit got;
    logic [15:0] a, b;
    bus.start = 1'b0;
    bus.bin   = '0;
`ifdef FIBO_AUTO_CAPTURE_EN
    bus.fibo_ready = 1'b1;
`endif
    // Reset for two cycles.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(fibo_pkg::ST_IDLE));

`ifdef FIBO_AUTO_CAPTURE_EN
    // Ready high out of reset must not start a conversion.
    pulses = 0;
    repeat (25) begin
      @(negedge clock);
      if (bus.done === 1'b1) pulses++;
    end
    chk("auto_no_trig", 32'(pulses), 32'd0);
`endif

    // Directed values.
    conv(16'd0, 0);
    conv(16'd65535, 0);
    conv(16'd97, 0);
    conv(16'd1234, 0);
    // Start during a conversion is ignored, then a fresh start works.
    conv(16'd321, 5);
    conv(16'd9999, 0);

    // Reset on the 8th shift cycle aborts with no done pulse.
    bus.bin   = 16'd1234;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_state", 32'(bus.state), 32'(fibo_pkg::ST_IDLE));
    chk("abort_bcd", 32'(bus.bcd), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    conv(16'd42, 0);

    // start held high: back-to-back conversions, new bin taken at IDLE.
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(0, 65535));
    bus.bin   = a;
    bus.start = 1'b1;
    exp_q.push_back(bcd_ref(32'(a)));
    wait_done(cyc, got);
    chk("hold_done1", 32'(got), 32'd1);
    chk("hold_bcd1", 32'(bus.bcd), 32'(exp_q.pop_front()));
    bus.bin = b;
    exp_q.push_back(bcd_ref(32'(b)));
    wait_done(cyc, got);
    bus.start = 1'b0;
    chk("hold_period", 32'(cyc), 32'd18);
    chk("hold_bcd2", 32'(bus.bcd), 32'(exp_q.pop_front()));
    @(negedge clock);
    chk("hold_ready", 32'(bus.ready), 32'd1);

    // Randomized conversions with random gaps and stray starts.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      conv(16'($urandom_range(0, 65535)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16)) : 0);
    end

`ifdef FIBO_AUTO_CAPTURE_EN
    // Counter Ready falls, then rises with its result; start stays 0.
    bus.fibo_ready = 1'b0;
    @(negedge clock);
    bus.bin = 16'd97;
    bus.fibo_ready = 1'b1;
    exp_q.push_back(bcd_ref(32'd97));
    @(negedge clock);
    bus.bin = 16'd5;
    wait_done(cyc, got);
    chk("auto_done", 32'(got), 32'd1);
    chk("auto_latency", 32'(cyc), 32'd16);
    chk("auto_bcd", 32'(bus.bcd), 32'(exp_q.pop_front()));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
